// File: rtl/ahb_arbiter_if.sv
// Two-master AHB arbitration bus: per-master request/address-phase signals in,
// grants and the muxed bridge-side transfer out.
interface ahb_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              Hbusreq0, Hbusreq1;
  logic [ADDR_W-1:0] Haddr0, Haddr1;
  logic [1:0]        Htrans0, Htrans1;
  logic              Hwrite0, Hwrite1;
  logic [DATA_W-1:0] Hwdata0, Hwdata1;
  logic              Hreadyout;
  logic              Hgrant0, Hgrant1;
  logic              Hmaster;
  logic [ADDR_W-1:0] Haddr;
  logic [1:0]        Htrans;
  logic              Hwrite;
  logic [DATA_W-1:0] Hwdata;
  logic              Hreadyin;

  // Handshake: a transfer phase advances only on a rising edge where Hreadyout=1;
  // while it is 0 every arbitration output holds its value.

  // Arbiter side.
  modport slave (
    input  Hbusreq0, Hbusreq1, Haddr0, Haddr1, Htrans0, Htrans1,
           Hwrite0, Hwrite1, Hwdata0, Hwdata1, Hreadyout,
    output Hgrant0, Hgrant1, Hmaster, Haddr, Htrans, Hwrite, Hwdata, Hreadyin
  );

  // Requesting-master / bridge side.
  modport master (
    output Hbusreq0, Hbusreq1, Haddr0, Haddr1, Htrans0, Htrans1,
           Hwrite0, Hwrite1, Hwdata0, Hwdata1, Hreadyout,
    input  Hgrant0, Hgrant1, Hmaster, Haddr, Htrans, Hwrite, Hwdata, Hreadyin
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Two-master AHB arbiter with burst lock and one-edge handover.
// Define ARB_ROUND_ROBIN_EN for round-robin priority; default is fixed master-0 priority.
module ahb_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               Hclk,
  input  logic               Hresetn,
  ahb_arbiter_if.slave       bus,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   grant0_q, grant1_q;
  logic   hmaster_q;
  logic   downer_q;
  logic   fav1;
  logic   lock0, lock1;
  logic   req0, req1;
  logic [DATA_W-1:0] wdata_sel;

`ifdef ARB_ROUND_ROBIN_EN
  logic ptr_q;
  assign fav1 = ptr_q;
`else
  assign fav1 = 1'b0;
`endif

  assign req0  = bus.Hbusreq0;
  assign req1  = bus.Hbusreq1;
  // SEQ (11) and BUSY (01) both have bit 0 set: the owner is mid-burst.
  assign lock0 = bus.Htrans0[0];
  assign lock1 = bus.Htrans1[0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1)  state_d = fav1 ? ST_OWN1 : ST_OWN0;
        else if (req0)     state_d = ST_OWN0;
        else if (req1)     state_d = ST_OWN1;
        else               state_d = ST_IDLE;
      end
      ST_OWN0: begin
        if (!lock0) begin
          if (req1 && (!req0 || fav1)) state_d = ST_OWN1;
          else if (req0)               state_d = ST_OWN0;
          else                         state_d = ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (!lock1) begin
          if (req0 && (!req1 || !fav1)) state_d = ST_OWN0;
          else if (req1)                state_d = ST_OWN1;
          else                          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state_q   <= ST_IDLE;
      grant0_q  <= 1'b0;
      grant1_q  <= 1'b0;
      hmaster_q <= 1'b0;
      downer_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q     <= 1'b0;
`endif
    end else if (bus.Hreadyout) begin
      state_q  <= state_d;
      grant0_q <= (state_d == ST_OWN0);
      grant1_q <= (state_d == ST_OWN1);
      downer_q <= hmaster_q;
      // Hmaster keeps the last owner through IDLE so its final data phase stays routed.
      if (state_d == ST_OWN0) hmaster_q <= 1'b0;
      else if (state_d == ST_OWN1) hmaster_q <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      if (state_d == ST_OWN0) ptr_q <= 1'b1;
      else if (state_d == ST_OWN1) ptr_q <= 1'b0;
`endif
    end
  end

  assign wdata_sel = downer_q ? bus.Hwdata1 : bus.Hwdata0;

  always_comb begin
    bus.Haddr  = {ADDR_W{1'b0}};
    bus.Htrans = 2'b00;
    bus.Hwrite = 1'b0;
    if (state_q != ST_IDLE) begin
      bus.Haddr  = hmaster_q ? bus.Haddr1  : bus.Haddr0;
      bus.Htrans = hmaster_q ? bus.Htrans1 : bus.Htrans0;
      bus.Hwrite = hmaster_q ? bus.Hwrite1 : bus.Hwrite0;
    end
  end

  assign bus.Hwdata   = wdata_sel;
  assign bus.Hgrant0  = grant0_q;
  assign bus.Hgrant1  = grant1_q;
  assign bus.Hmaster  = hmaster_q;
  assign bus.Hreadyin = bus.Hreadyout;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: directed scenarios then random traffic, all checked
// against a transaction-level ownership model.
module tb_ahb_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  logic       Hclk;
  logic       Hresetn;
  logic [1:0] dbg_state;

  ahb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ahb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Hclk        (Hclk),
    .Hresetn     (Hresetn),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    Hclk = 1'b0;
    forever #5 Hclk = ~Hclk;
  end

  int n_checks = 0;
  int n_err    = 0;

  // ---------------- reference model ----------------
  // Owner is -1 (nobody), 0 or 1; fav is the master that wins a tie.
  int   m_own = -1;
  logic m_hm  = 1'b0;
  logic m_dw  = 1'b0;
  logic m_ptr = 1'b0;
  int   m_nxt, m_fav, m_oth;
  logic m_rq[2];
  logic [1:0] m_tr[2];

  always @(posedge Hclk) begin
    if (!Hresetn) begin
      m_own = -1; m_hm = 1'b0; m_dw = 1'b0; m_ptr = 1'b0;
    end else if (bus.Hreadyout) begin
      m_rq[0] = bus.Hbusreq0; m_rq[1] = bus.Hbusreq1;
      m_tr[0] = bus.Htrans0;  m_tr[1] = bus.Htrans1;
`ifdef ARB_ROUND_ROBIN_EN
      m_fav = int'(m_ptr);
`else
      m_fav = 0;
`endif
      m_dw  = m_hm;
      m_nxt = m_own;
      if (m_own < 0) begin
        if (m_rq[0] && m_rq[1]) m_nxt = m_fav;
        else if (m_rq[0])       m_nxt = 0;
        else if (m_rq[1])       m_nxt = 1;
        else                    m_nxt = -1;
      end else if (m_tr[m_own] == T_SEQ || m_tr[m_own] == T_BUSY) begin
        m_nxt = m_own;
      end else begin
        m_oth = 1 - m_own;
        if (m_rq[m_oth] && (!m_rq[m_own] || m_fav == m_oth)) m_nxt = m_oth;
        else if (m_rq[m_own])                                 m_nxt = m_own;
        else                                                  m_nxt = -1;
      end
      if (m_nxt >= 0) begin
        m_hm  = m_nxt[0];
        m_ptr = ~m_nxt[0];
      end
      m_own = m_nxt;
    end
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [63:0] obs_v[9];
  string       names[9] = '{"grant0", "grant1", "hmaster", "haddr", "htrans",
                            "hwrite", "hwdata", "hreadyin", "one_hot"};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [63:0] e;
    exp_q.push_back(64'(m_own == 0));
    exp_q.push_back(64'(m_own == 1));
    exp_q.push_back(64'(m_hm));
    exp_q.push_back(m_own < 0 ? 64'd0 : 64'(m_hm ? bus.Haddr1 : bus.Haddr0));
    exp_q.push_back(m_own < 0 ? 64'd0 : 64'(m_hm ? bus.Htrans1 : bus.Htrans0));
    exp_q.push_back(m_own < 0 ? 64'd0 : 64'(m_hm ? bus.Hwrite1 : bus.Hwrite0));
    exp_q.push_back(64'(m_dw ? bus.Hwdata1 : bus.Hwdata0));
    exp_q.push_back(64'(bus.Hreadyout));
    exp_q.push_back(64'd0);
    obs_v[0] = 64'(bus.Hgrant0);
    obs_v[1] = 64'(bus.Hgrant1);
    obs_v[2] = 64'(bus.Hmaster);
    obs_v[3] = 64'(bus.Haddr);
    obs_v[4] = 64'(bus.Htrans);
    obs_v[5] = 64'(bus.Hwrite);
    obs_v[6] = 64'(bus.Hwdata);
    obs_v[7] = 64'(bus.Hreadyin);
    obs_v[8] = 64'(bus.Hgrant0 & bus.Hgrant1);
    for (int i = 0; i < 9; i++) begin
      e = exp_q.pop_front();
      chk({tag, ".", names[i]}, obs_v[i], e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input string tag);
    @(posedge Hclk);
    @(negedge Hclk);
    check_outputs(tag);
  endtask

  task automatic drive_m(input int m, input logic req, input logic [1:0] tr,
                         input logic [31:0] a, input logic w, input logic [31:0] d);
    if (m == 0) begin
      bus.Hbusreq0 = req; bus.Htrans0 = tr; bus.Haddr0 = a; bus.Hwrite0 = w; bus.Hwdata0 = d;
    end else begin
      bus.Hbusreq1 = req; bus.Htrans1 = tr; bus.Haddr1 = a; bus.Hwrite1 = w; bus.Hwdata1 = d;
    end
  endtask

  task automatic all_idle();
    drive_m(0, 1'b0, T_IDLE, 32'h0, 1'b0, 32'h0);
    drive_m(1, 1'b0, T_IDLE, 32'h0, 1'b0, 32'h0);
    bus.Hreadyout = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Hresetn = 1'b0;
    all_idle();
    @(negedge Hclk);

    // Reset state
    tick("rst"); tick("rst");
    chk("rst_grant0", bus.Hgrant0, 1'b0);
    chk("rst_grant1", bus.Hgrant1, 1'b0);
    chk("rst_hmaster", bus.Hmaster, 1'b0);
    chk("rst_htrans", bus.Htrans, 2'b00);
    Hresetn = 1'b1;
    tick("rel");

    // Single requester granted one edge later
    drive_m(0, 1'b1, T_NSEQ, 32'h8000_0000, 1'b1, 32'hD0D0_0001);
    tick("single");
    chk("single_grant0", bus.Hgrant0, 1'b1);
    chk("single_haddr", bus.Haddr, 32'h8000_0000);
    chk("single_htrans", bus.Htrans, T_NSEQ);

    // Master 0 four-beat burst; master 1 requests from beat 2
    tick("beat1");
    drive_m(1, 1'b1, T_NSEQ, 32'h4000_0000, 1'b0, 32'h1111_1111);
    for (int b = 2; b <= 4; b++) begin
      drive_m(0, 1'b1, T_SEQ, 32'h8000_0000 + 32'((b - 1) * 4), 1'b1, 32'hD0D0_0000 + 32'(b));
      tick("burst");
      chk("burst_lock_grant1", bus.Hgrant1, 1'b0);
    end
    drive_m(0, 1'b0, T_IDLE, 32'h0, 1'b0, 32'h0000_00AA);
    tick("burst_end");
    chk("handover_grant1", bus.Hgrant1, 1'b1);
    chk("handover_hmaster", bus.Hmaster, 1'b1);

    // Stalled handover: everything holds while Hreadyout=0
    tick("m1_data");
    drive_m(0, 1'b1, T_NSEQ, 32'h8000_0100, 1'b0, 32'h0000_00AA);
    drive_m(1, 1'b0, T_IDLE, 32'h4000_0000, 1'b0, 32'h1111_1111);
    bus.Hreadyout = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick("stall");
      chk("stall_grant1", bus.Hgrant1, 1'b1);
      chk("stall_hmaster", bus.Hmaster, 1'b1);
      chk("stall_hwdata", bus.Hwdata, 32'h1111_1111);
    end
    bus.Hreadyout = 1'b1;
    tick("unstall");
    chk("unstall_grant0", bus.Hgrant0, 1'b1);
    chk("unstall_hwdata", bus.Hwdata, 32'h1111_1111);
    tick("after");
    chk("after_hwdata", bus.Hwdata, 32'h0000_00AA);

    // Reset during master 1 SEQ beat
    drive_m(0, 1'b0, T_IDLE, 32'h0, 1'b0, 32'h0);
    drive_m(1, 1'b1, T_NSEQ, 32'h4000_0010, 1'b1, 32'h2222_2222);
    tick("to_m1");
    chk("to_m1_grant1", bus.Hgrant1, 1'b1);
    drive_m(1, 1'b1, T_SEQ, 32'h4000_0014, 1'b1, 32'h2222_2223);
    Hresetn = 1'b0;
    tick("rst_burst");
    chk("rstb_grant1", bus.Hgrant1, 1'b0);
    chk("rstb_hmaster", bus.Hmaster, 1'b0);
    chk("rstb_htrans", bus.Htrans, 2'b00);
    all_idle();
    tick("rst2");
    Hresetn = 1'b1;
    tick("rel2");

    // Simultaneous requests from IDLE
    drive_m(0, 1'b1, T_NSEQ, 32'h8000_0200, 1'b0, 32'h3);
    drive_m(1, 1'b1, T_NSEQ, 32'h4000_0200, 1'b0, 32'h4);
    tick("both");
    chk("both_grant0", bus.Hgrant0, 1'b1);
`ifdef ARB_ROUND_ROBIN_EN
    tick("rr_turn");
    chk("rr_grant1", bus.Hgrant1, 1'b1);
`else
    drive_m(0, 1'b0, T_IDLE, 32'h0, 1'b0, 32'h3);
    tick("fp_m1");
    chk("fp_m1_grant1", bus.Hgrant1, 1'b1);
    drive_m(0, 1'b1, T_NSEQ, 32'h8000_0300, 1'b0, 32'h3);
    tick("fp_preempt");
    chk("fp_preempt_grant0", bus.Hgrant0, 1'b1);
`endif

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      Hresetn       = ($urandom_range(0, 49) != 0);
      bus.Hreadyout = ($urandom_range(0, 3) != 0);
      drive_m(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)), $urandom);
      drive_m(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)), $urandom);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
